// File: rtl/tc_pkg.sv
// Purpose: shared constants for the TC serial receiver (frame geometry,
//          FSM state encoding, rx_status bit positions, status packer).
// Latency: n/a (package). Backpressure: n/a.
package tc_pkg;

  localparam int TC_NUM_WORDS = 10;
  localparam int TC_WORD_W    = 32;

  // Receiver FSM encoding, kept as plain constants so the status/debug
  // tooling that decodes the raw state value keeps working.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SKIP   = 2'd1;
  localparam logic [1:0] ST_RECV   = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  // rx_status field positions
  localparam int STS_FRAME_VALID  = 0;
  localparam int STS_BUSY         = 1;
  localparam int STS_TIMEOUT_ERR  = 2;
  localparam int STS_OVERRUN      = 3;
  localparam int STS_WORD_IDX_LSB = 4;
  localparam int STS_BIT_IDX_LSB  = 8;

  // Assemble the status word; every bit not listed reads 0.
  function automatic logic [31:0] tc_status_word(
    input logic       frame_valid,
    input logic       busy,
    input logic       timeout_err,
    input logic       overrun,
    input logic [3:0] word_idx,
    input logic [4:0] bit_idx
  );
    logic [31:0] w;
    w                          = '0;
    w[STS_FRAME_VALID]         = frame_valid;
    w[STS_BUSY]                = busy;
    w[STS_TIMEOUT_ERR]         = timeout_err;
    w[STS_OVERRUN]             = overrun;
    w[STS_WORD_IDX_LSB +: 4]   = word_idx;
    w[STS_BIT_IDX_LSB +: 5]    = bit_idx;
    return w;
  endfunction

endpackage

// File: rtl/tc_rx_edge_sync.sv
// Purpose: 2-flop synchronizer plus edge detect for one asynchronous input.
// Latency: input change to sync_q/rise/fall = 3 sysclk edges (all outputs aligned).
// Backpressure: none; edges closer than 3 sysclk periods apart may be lost.
// Ports: sysclk, reset (sync, active-high), d (async input),
//        sync_q (synchronized level), rise/fall (one-cycle edge pulses).
module tc_rx_edge_sync (
  input  logic sysclk,
  input  logic reset,
  input  logic d,
  output logic sync_q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      hist <= sync;
      rise <= sync & ~hist;
      fall <= ~sync & hist;
    end
  end

  // hist is updated on the same edge that registers rise/fall, so the level
  // and the edge pulses come out of the block with identical latency.
  assign sync_q = hist;

endmodule

// File: rtl/tc_rx_deserializer.sv
// Purpose: TC serial receiver; samples sin on tcclk_in falling edges and
//          deserializes a 10 x 32-bit frame (word 1 first, MSB first).
// Latency: last tcclk_in falling edge to rx_reg*/frame_valid update = 5 sysclk.
// Backpressure: none; a new frame overwrites rx_reg* and raises overrun if
//          frame_valid was not cleared.
// Ports: sysclk, reset (sync, active-high), rx_en, rx_clr (flag clear pulse),
//        tcclk_in/sin (async serial pair), rx_reg1..rx_reg10 (last committed
//        frame), rx_status (frame_valid, busy, timeout_err, overrun,
//        word_idx[7:4], bit_idx[12:8]).
// Build option: define TC_RX_TIMEOUT_EN to add the stalled-frame watchdog;
//        without it rx_status[2] reads 0 and a stalled frame waits forever.
module tc_rx_deserializer
  import tc_pkg::*;
#(
  parameter int NUM_WORDS = TC_NUM_WORDS,
  parameter int WORD_W    = TC_WORD_W,
  parameter int SKIP_BITS = 0,
  parameter int TIMEOUT   = 1024
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              rx_en,
  input  logic              rx_clr,
  input  logic              tcclk_in,
  input  logic              sin,
  output logic [WORD_W-1:0] rx_reg1,
  output logic [WORD_W-1:0] rx_reg2,
  output logic [WORD_W-1:0] rx_reg3,
  output logic [WORD_W-1:0] rx_reg4,
  output logic [WORD_W-1:0] rx_reg5,
  output logic [WORD_W-1:0] rx_reg6,
  output logic [WORD_W-1:0] rx_reg7,
  output logic [WORD_W-1:0] rx_reg8,
  output logic [WORD_W-1:0] rx_reg9,
  output logic [WORD_W-1:0] rx_reg10,
  output logic [31:0]       rx_status
);

  localparam logic [3:0] LAST_WORD = 4'(NUM_WORDS - 1);
  localparam logic [4:0] LAST_BIT  = 5'(WORD_W - 1);
  localparam logic [7:0] LAST_SKIP = 8'(SKIP_BITS - 1);

  // ---------------------------------------------------------------------------
  // Input synchronization (both paths share the same pipeline depth)
  // ---------------------------------------------------------------------------
  logic clk_sync, clk_rise, clk_fall;
  logic sin_sync, sin_rise, sin_fall;

  tc_rx_edge_sync u_clk_sync (
    .sysclk (sysclk),
    .reset  (reset),
    .d      (tcclk_in),
    .sync_q (clk_sync),
    .rise   (clk_rise),
    .fall   (clk_fall)
  );

  tc_rx_edge_sync u_sin_sync (
    .sysclk (sysclk),
    .reset  (reset),
    .d      (sin),
    .sync_q (sin_sync),
    .rise   (sin_rise),
    .fall   (sin_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{clk_sync, clk_rise, sin_rise, sin_fall};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        state;
  logic [7:0]        skip_cnt;
  logic [4:0]        bit_idx;
  logic [3:0]        word_idx;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] stage [NUM_WORDS];
  logic [WORD_W-1:0] rx_q  [NUM_WORDS];
  logic              frame_valid;
  logic              overrun;
  logic              timeout_err;

  logic              in_frame;
  logic [WORD_W-1:0] shreg_nxt;
  logic              wd_expire;

  assign in_frame  = (state == ST_SKIP) || (state == ST_RECV);
  assign shreg_nxt = {shreg[WORD_W-2:0], sin_sync};

  // ---------------------------------------------------------------------------
  // Stalled-frame watchdog
  // ---------------------------------------------------------------------------
`ifdef TC_RX_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Restarts on every consumed falling edge and whenever no frame is open,
  // so wd_cnt is the number of sysclk cycles since the last edge.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (in_frame && !clk_fall) begin
      wd_cnt <= wd_cnt + 16'd1;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign wd_expire = in_frame && rx_en && !clk_fall && (wd_cnt == 16'(TIMEOUT - 1));
`else
  assign wd_expire = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Receive FSM and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
      bit_idx  <= '0;
      word_idx <= '0;
      shreg    <= '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        stage[i] <= '0;
        rx_q[i]  <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          skip_cnt <= '0;
          bit_idx  <= '0;
          word_idx <= '0;
          if (clk_fall && rx_en) begin
            // The opening edge is already bit 0: either the first skipped
            // bit or, with nothing to skip, the first data bit.
            if (SKIP_BITS == 0) begin
              shreg   <= shreg_nxt;
              bit_idx <= 5'd1;
              state   <= ST_RECV;
            end else begin
              skip_cnt <= 8'd1;
              state    <= (SKIP_BITS == 1) ? ST_RECV : ST_SKIP;
            end
          end
        end

        ST_SKIP: begin
          if (!rx_en || wd_expire) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
          end else if (clk_fall) begin
            if (skip_cnt == LAST_SKIP) begin
              skip_cnt <= '0;
              state    <= ST_RECV;
            end else begin
              skip_cnt <= skip_cnt + 8'd1;
            end
          end
        end

        ST_RECV: begin
          if (!rx_en || wd_expire) begin
            state    <= ST_IDLE;
            bit_idx  <= '0;
            word_idx <= '0;
          end else if (clk_fall) begin
            shreg <= shreg_nxt;
            if (bit_idx == LAST_BIT) begin
              stage[word_idx] <= shreg_nxt;
              bit_idx         <= '0;
              word_idx        <= word_idx + 4'd1;
              if (word_idx == LAST_WORD) begin
                state <= ST_COMMIT;
              end
            end else begin
              bit_idx <= bit_idx + 5'd1;
            end
          end
        end

        default: begin  // ST_COMMIT
          rx_q     <= stage;
          bit_idx  <= '0;
          word_idx <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky status flags. Later assignments win: a clear coinciding with a
  // commit still leaves frame_valid set, and overrun reflects the
  // frame_valid value seen before that clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (reset) begin
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (rx_clr) begin
        frame_valid <= 1'b0;
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (state == ST_COMMIT) begin
        frame_valid <= 1'b1;
        overrun     <= frame_valid | (overrun & ~rx_clr);
      end
      if (wd_expire) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rx_reg1  = rx_q[0];
  assign rx_reg2  = rx_q[1];
  assign rx_reg3  = rx_q[2];
  assign rx_reg4  = rx_q[3];
  assign rx_reg5  = rx_q[4];
  assign rx_reg6  = rx_q[5];
  assign rx_reg7  = rx_q[6];
  assign rx_reg8  = rx_q[7];
  assign rx_reg9  = rx_q[8];
  assign rx_reg10 = rx_q[9];

  assign rx_status = tc_status_word(frame_valid, state != ST_IDLE, timeout_err,
                                    overrun, word_idx, bit_idx);

endmodule

// File: tb/tb_tc_rx_deserializer.sv
module tb_tc_rx_deserializer;

  logic        sysclk = 1'b0;
  logic        reset, rx_en, rx_clr;
  logic        tc_a, sin_a, tc_b, sin_b;
  logic [31:0] a_reg1, a_reg2, a_reg3, a_reg4, a_reg5, a_reg6, a_reg7, a_reg8, a_reg9, a_reg10;
  logic [31:0] b_reg1, b_reg2, b_reg3, b_reg4, b_reg5, b_reg6, b_reg7, b_reg8, b_reg9, b_reg10;
  logic [31:0] a_status, b_status;

  always #5 sysclk = ~sysclk;

  tc_rx_deserializer #(.SKIP_BITS(0), .TIMEOUT(100)) dut (
    .sysclk(sysclk), .reset(reset), .rx_en(rx_en), .rx_clr(rx_clr),
    .tcclk_in(tc_a), .sin(sin_a),
    .rx_reg1(a_reg1), .rx_reg2(a_reg2), .rx_reg3(a_reg3), .rx_reg4(a_reg4), .rx_reg5(a_reg5),
    .rx_reg6(a_reg6), .rx_reg7(a_reg7), .rx_reg8(a_reg8), .rx_reg9(a_reg9), .rx_reg10(a_reg10),
    .rx_status(a_status)
  );

  tc_rx_deserializer #(.SKIP_BITS(64), .TIMEOUT(100)) dut_skip (
    .sysclk(sysclk), .reset(reset), .rx_en(rx_en), .rx_clr(rx_clr),
    .tcclk_in(tc_b), .sin(sin_b),
    .rx_reg1(b_reg1), .rx_reg2(b_reg2), .rx_reg3(b_reg3), .rx_reg4(b_reg4), .rx_reg5(b_reg5),
    .rx_reg6(b_reg6), .rx_reg7(b_reg7), .rx_reg8(b_reg8), .rx_reg9(b_reg9), .rx_reg10(b_reg10),
    .rx_status(b_status)
  );

  // Behavioural model of the main instance: the frame last handed over and
  // the three sticky flags, updated at the cycle the receiver must commit.
  logic [319:0] exp_frame;
  logic         exp_fv, exp_ov, exp_to;
  logic         chk_en;
  int           n_chk, n_fail;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One sysclk cycle: model comparison on the falling sysclk edge, then
  // return just after the next rising edge where stimulus is driven.
  task automatic tick();
    logic [319:0] got_frame;
    @(negedge sysclk);
    if (chk_en) begin
      got_frame = {a_reg1, a_reg2, a_reg3, a_reg4, a_reg5, a_reg6, a_reg7, a_reg8, a_reg9, a_reg10};
      n_chk++;
      if (got_frame !== exp_frame) begin
        n_fail++;
        $display("FAIL rx_regs @%0t: got %h expected %h", $time, got_frame, exp_frame);
      end
      n_chk++;
      if ({a_status[3], a_status[2], a_status[0]} !== {exp_ov, exp_to, exp_fv}) begin
        n_fail++;
        $display("FAIL flags(ov,to,fv) @%0t: got %b expected %b", $time,
                 {a_status[3], a_status[2], a_status[0]}, {exp_ov, exp_to, exp_fv});
      end
    end
    @(posedge sysclk);
    #1;
  endtask

  // One bit, tcclk period 8 sysclk: data launched with the rising edge,
  // taken by the receiver on the falling edge.
  task automatic send_bit(input logic b, input int inst);
    if (inst == 0) begin tc_a = 1'b1; sin_a = b; end
    else           begin tc_b = 1'b1; sin_b = b; end
    repeat (4) tick();
    if (inst == 0) tc_a = 1'b0;
    else           tc_b = 1'b0;
    repeat (4) tick();
  endtask

  task automatic send_bits(input logic [383:0] bits, input int n, input int inst);
    for (int i = 0; i < n; i++) send_bit(bits[383-i], inst);
  endtask

  function automatic logic [319:0] mk_inc(input logic [31:0] base);
    logic [319:0] f;
    for (int k = 0; k < 10; k++) f[319-32*k -: 32] = base + 32'(k);
    return f;
  endfunction

  task automatic commit_model(input logic [319:0] f, input logic clr);
    exp_ov    = clr ? exp_fv : (exp_ov | exp_fv);
    if (clr) exp_to = 1'b0;
    exp_fv    = 1'b1;
    exp_frame = f;
  endtask

  task automatic clear_model();
    exp_fv = 1'b0; exp_ov = 1'b0; exp_to = 1'b0;
  endtask

  task automatic pulse_clr();
    rx_clr = 1'b1;
    tick();
    rx_clr = 1'b0;
    clear_model();
  endtask

  logic [319:0] f1, f2, fs, fp, fa, fc;

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 1'b0;
    reset = 1'b1; rx_en = 1'b0; rx_clr = 1'b0;
    tc_a = 1'b0; sin_a = 1'b0; tc_b = 1'b0; sin_b = 1'b0;
    exp_frame = '0; clear_model();
    repeat (3) tick();
    chk("reset rx_status", a_status, 32'h0);
    chk("reset rx_reg1", a_reg1, 32'h0);
    chk("reset rx_reg10", a_reg10, 32'h0);
    reset = 1'b0; rx_en = 1'b1; chk_en = 1'b1;
    tick();

    // Frame 1: words 1..10; frame_valid exactly 5 cycles after last fall
    f1 = mk_inc(32'h1);
    send_bits({f1, 64'h0}, 320, 0);
    chk("fv 4 cycles after last edge", 32'(a_status[0]), 32'h0);
    tick();
    commit_model(f1, 1'b0);
    chk("fv 5 cycles after last edge", 32'(a_status[0]), 32'h1);
    chk("frame1 rx_reg1", a_reg1, 32'h00000001);
    chk("frame1 rx_reg10", a_reg10, 32'h0000000A);
    chk("frame1 overrun", 32'(a_status[3]), 32'h0);
    chk("frame1 busy after commit", 32'(a_status[1]), 32'h0);

    // Frame 2 without clearing: overwrite and overrun
    f2 = {10{32'hA5A5A5A5}};
    send_bits({f2, 64'h0}, 320, 0);
    tick();
    commit_model(f2, 1'b0);
    chk("frame2 rx_reg5", a_reg5, 32'hA5A5A5A5);
    chk("frame2 overrun", 32'(a_status[3]), 32'h1);
    pulse_clr();
    chk("clr status[3:0]", 32'(a_status[3:0]), 32'h0);

    // 64 skipped bits ahead of the frame on the SKIP_BITS=64 instance
    fs = mk_inc(32'h1);
    fs[319 -: 32] = 32'hDEADBEEF;
    send_bits({64'h0, fs}, 384, 1);
    tick();
    chk("skip rx_reg1", b_reg1, 32'hDEADBEEF);
    chk("skip rx_reg2", b_reg2, 32'h00000002);
    chk("skip rx_reg10", b_reg10, 32'h0000000A);
    chk("skip frame_valid", 32'(b_status[0]), 32'h1);

    // Live progress after 40 bits: word 1, bit 8
    fp = mk_inc(32'h100);
    send_bits({fp, 64'h0}, 40, 0);
    chk("progress word_idx", 32'(a_status[7:4]), 32'd1);
    chk("progress bit_idx", 32'(a_status[12:8]), 32'd8);
    chk("progress busy", 32'(a_status[1]), 32'h1);
`ifdef TC_RX_TIMEOUT_EN
    repeat (99) tick();
    chk("timeout not yet", 32'(a_status[2]), 32'h0);
    chk("busy before timeout", 32'(a_status[1]), 32'h1);
    tick();
    exp_to = 1'b1;
    chk("timeout_err", 32'(a_status[2]), 32'h1);
    chk("busy after timeout", 32'(a_status[1]), 32'h0);
    chk("rx_reg1 kept on timeout", a_reg1, 32'hA5A5A5A5);
    send_bits({fp, 64'h0}, 320, 0);
    tick();
    commit_model(fp, 1'b0);
    chk("frame after timeout rx_reg3", a_reg3, 32'h00000102);
    pulse_clr();
`else
    rx_en = 1'b0;
    tick();
    rx_en = 1'b1;
    chk("busy after progress abort", 32'(a_status[1]), 32'h0);
`endif

    // rx_en dropped after 150 bits: word 4, bit 22, then silent abort
    fa = mk_inc(32'h200);
    send_bits({fa, 64'h0}, 150, 0);
    chk("abort word_idx", 32'(a_status[7:4]), 32'd4);
    chk("abort bit_idx", 32'(a_status[12:8]), 32'd22);
    rx_en = 1'b0;
    tick();
    chk("abort busy", 32'(a_status[1]), 32'h0);
    chk("abort status", a_status, 32'h0);
    rx_en = 1'b1;
    tick();

    // rx_clr coinciding with COMMIT: set wins
    fc = mk_inc(32'h300);
    send_bits({fc, 64'h0}, 320, 0);
    rx_clr = 1'b1;
    tick();
    rx_clr = 1'b0;
    commit_model(fc, 1'b1);
    chk("clr+commit frame_valid", 32'(a_status[0]), 32'h1);
    chk("clr+commit overrun", 32'(a_status[3]), 32'h0);
    chk("clr+commit rx_reg1", a_reg1, 32'h00000300);

    // reset in the middle of a frame
    send_bits({fa, 64'h0}, 50, 0);
    reset = 1'b1;
    tick();
    exp_frame = '0;
    clear_model();
    chk("mid-frame reset status", a_status, 32'h0);
    chk("mid-frame reset rx_reg1", a_reg1, 32'h0);
    reset = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tc_rx_deserializer.md
# tc_rx_deserializer

Telecommand serial receiver: the far end of the TC serial link, with the transmitter on the near end. It runs on `sysclk`, oversamples the incoming `tcclk_in`/`sin` pair and deserializes one 320-bit frame (10 × 32-bit words, word 1 first, MSB first) into ten output data registers. It reports frame status to the AXI slave-register block through a status word, with sticky flags cleared by software.

## Interface
Parameters:
- `NUM_WORDS`, 10: words per frame.
- `WORD_W`, 32: bits per word.
- `SKIP_BITS`, 0: leading bits discarded at frame start (range 0–255).
- `TIMEOUT`, 1024: `sysclk` cycles without a `tcclk_in` falling edge before a frame in progress is aborted (range 16–65535).

Ports:
- `sysclk`, in, 1: the only clock.
- `reset`, in, 1: synchronous, active-high.
- `rx_en`, in, 1: receiver enable (control reg bit 0).
- `rx_clr`, in, 1: one-cycle pulse; clears the sticky status flags.
- `tcclk_in`, in, 1: asynchronous TC serial clock.
- `sin`, in, 1: asynchronous TC serial data.
- `rx_reg1` … `rx_reg10`, out, 32 each: last committed frame.
- `rx_status`, out, 32: status word.
  - [0] `frame_valid`
  - [1] `busy`
  - [2] `timeout_err`
  - [3] `overrun`
  - [7:4] `word_idx`
  - [12:8] `bit_idx`
  - all other bits 0.

## Operation
- `tcclk_in` and `sin` each pass through a 2-flop synchronizer, then a third register for edge detect.
  - A data bit is taken on each synchronized falling edge of `tcclk_in`. The transmitter launches data on the rising edge.
- FSM states: IDLE, SKIP, RECV, COMMIT.
  - IDLE → SKIP on the first falling edge with `rx_en`=1. That edge counts as bit 0.
    - If `SKIP_BITS`=0, go directly to RECV, and that edge's bit is data bit 0.
  - SKIP → RECV after `SKIP_BITS` edges.
  - RECV: shift `sin` into a 32-bit shift register, MSB first.
    - Every 32nd bit, write the shift register to staging word `word_idx`, then increment `word_idx`.
    - After the 320th data bit, go to COMMIT.
  - COMMIT: in one cycle, copy all 10 staging words into `rx_reg1..10` and set `frame_valid`.
    - If `frame_valid` was already 1 (not cleared), also set `overrun`. Data is overwritten regardless.
    - Then return to IDLE.
- `rx_en`=0 in SKIP or RECV: abort to IDLE. No commit, no flag set, outputs unchanged.
- `busy`=1 in SKIP, RECV and COMMIT.
- `word_idx` and `bit_idx` show live progress and read 0 in IDLE.
- `rx_clr` clears `frame_valid`, `timeout_err` and `overrun`. If it coincides with COMMIT, set wins: `frame_valid`=1, and `overrun` is evaluated before the clear.
- Staging and output registers are separate, so `rx_reg*` always hold one complete, consistent frame.

## Timing
- Reset values: all `rx_reg*` = 0, `rx_status` = 0, state IDLE, synchronizer flops 0.
- `tcclk_in` high and low phases must each be ≥ 3 `sysclk` periods. Faster clocks are unsupported; edges may be missed.
- Falling edge of `tcclk_in` to sample: 3 `sysclk` cycles (2 sync + edge detect).
- The bit is in the shift register at cycle 4.
- Last bit's falling edge to `frame_valid`=1 with `rx_reg*` updated: exactly 5 `sysclk` cycles.
- `reset` mid-frame: immediate return to the reset state, partial frame discarded.
- Back-to-back frames: the receiver is in IDLE one cycle after COMMIT, well within one `tcclk` period, so no bits are lost.

## Configuration
- `TC_RX_TIMEOUT_EN` defined:
  - A 16-bit watchdog counts `sysclk` cycles in SKIP/RECV and resets on each falling edge.
  - When it reaches `TIMEOUT`: abort to IDLE, set `timeout_err` (sticky), leave `rx_reg*` unchanged.
- `TC_RX_TIMEOUT_EN` undefined:
  - No counter; `rx_status[2]` is tied 0.
  - A stalled frame waits indefinitely until `rx_en`=0 or `reset`.

## Structure
- Shared package `tc_pkg`:
  - constants `TC_NUM_WORDS`=10, `TC_WORD_W`=32;
  - FSM state encoding (IDLE=0, SKIP=1, RECV=2, COMMIT=3);
  - `rx_status` bit-position constants.
- One sub-module, `tc_rx_edge_sync`: 2-flop synchronizer plus edge detect for one signal, with outputs `sync_q`, `rise`, `fall`.
  - Instantiated twice: for `tcclk_in` (uses `fall`) and for `sin` (uses `sync_q`). Both paths have equal latency.

## Test plan
- Reset, `rx_en`=1, send 320 bits with `tcclk` period 8 `sysclk`, words 0x00000001 … 0x0000000A → `rx_reg1`=0x00000001 … `rx_reg10`=0x0000000A, `frame_valid`=1 exactly 5 cycles after the last falling edge, `overrun`=0.
- Second frame of all 0xA5A5A5A5 without `rx_clr` → all `rx_reg*`=0xA5A5A5A5, `overrun`=1. Then pulse `rx_clr` → `rx_status`[3:0]=0.
- `SKIP_BITS`=64, send 64 zeros then a 320-bit frame with `rx_reg1` pattern 0xDEADBEEF → `rx_reg1`=0xDEADBEEF and no word shift.
- `TC_RX_TIMEOUT_EN`, `TIMEOUT`=100: stop `tcclk` after 40 bits → `timeout_err`=1 at 100 cycles after the last edge, `busy`=0, `rx_reg*` unchanged. A subsequent full frame is then received correctly.
- Drop `rx_en` after 150 bits → `busy`=0 next cycle, no flags, `rx_reg*` unchanged. Assert `reset` mid-frame → `rx_status`=0.
- Assert `rx_clr` in the same cycle as COMMIT → `frame_valid`=1 afterwards.
